// File: rtl/qpsk_pkg.sv
`default_nettype none
// ============================================================================
// qpsk_pkg - shared constants, FSM state type and Gray-map encoding for QPSK TX
// Rev 1.0
// ============================================================================
package qpsk_pkg;

  localparam int SPS_DEFAULT     = 16;
  localparam int DIBITS_PER_WORD = 16;
  localparam int DIBIT_W         = 4;
  localparam int IQ_W            = 16;
  localparam int AMP_W           = IQ_W - 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic GRAY_POS = 1'b0;
  localparam logic GRAY_NEG = 1'b1;

endpackage
`default_nettype wire

// File: rtl/qpsk_dibit_mapper.sv
`default_nettype none
// ============================================================================
// qpsk_dibit_mapper - combinational Gray map of one dibit and magnitude to {I,Q}
// Rev 1.0
// ============================================================================
module qpsk_dibit_mapper
  import qpsk_pkg::*;
(
  input  logic [1:0]       dibit_i,
  input  logic [AMP_W-1:0] amp_i,
  output logic [IQ_W-1:0]  i_o,
  output logic [IQ_W-1:0]  q_o
);

  logic [IQ_W-1:0] w_pos;
  logic [IQ_W-1:0] w_neg;

  // Top bit of +A is always zero, so negation can never overflow.
  assign w_pos = {1'b0, amp_i};
  assign w_neg = -w_pos;

  assign i_o = (dibit_i[1] == GRAY_NEG) ? w_neg : w_pos;
  assign q_o = (dibit_i[0] == GRAY_NEG) ? w_neg : w_pos;

endmodule
`default_nettype wire

// File: rtl/qpsk_mod_tx.sv
`default_nettype none
// ============================================================================
// qpsk_mod_tx - QPSK modulator: 32-bit dibit words in, rectangular {I,Q} out
// Rev 1.0
// ============================================================================
module qpsk_mod_tx
  import qpsk_pkg::*;
#(
  parameter int SPS     = SPS_DEFAULT,
  parameter int PKT_LEN = 256
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic             clear,
  input  logic [AMP_W-1:0] amp,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             busy
);

  localparam int SC_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int PC_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [SC_W-1:0]    SAMP_LAST  = SC_W'(SPS - 1);
  localparam logic [PC_W-1:0]    PKT_LAST   = PC_W'(PKT_LEN - 1);
  localparam logic [DIBIT_W-1:0] DIBIT_LAST = DIBIT_W'(DIBITS_PER_WORD - 1);

  state_t             state_q, state_d;
  logic [31:0]        word_q, word_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic               last_q, last_d;
  logic [DIBIT_W-1:0] dibit_q, dibit_d;
  logic [SC_W-1:0]    samp_q, samp_d;
  logic [PC_W-1:0]    pkt_q, pkt_d;

  logic               w_run;
  logic               w_s_hs;
  logic               w_m_hs;
  logic               w_final;
  logic               w_tlast;
  logic [31:0]        w_shifted;
  logic [IQ_W-1:0]    w_i;
  logic [IQ_W-1:0]    w_q;

  assign w_run   = (state_q == RUN);
  assign w_final = (dibit_q == DIBIT_LAST) && (samp_q == SAMP_LAST);
  assign w_tlast = w_run && ((pkt_q == PKT_LAST) || (last_q && w_final));

  // Refuse input while a reset or flush is pending so no word is lost silently.
  assign s_axis_tready = !w_run && !ce_rst && !clear;
  assign w_s_hs        = s_axis_tvalid && s_axis_tready;
  assign w_m_hs        = w_run && m_axis_tready;

  assign w_shifted = word_q << {dibit_q, 1'b0};

  qpsk_dibit_mapper u_mapper (
    .dibit_i (w_shifted[31:30]),
    .amp_i   (amp_q),
    .i_o     (w_i),
    .q_o     (w_q)
  );

  assign m_axis_tvalid = w_run;
  assign m_axis_tdata  = w_run ? {w_i, w_q} : 32'h0;
  assign m_axis_tlast  = w_tlast;
  assign busy          = w_run;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    amp_d   = amp_q;
    last_d  = last_q;
    dibit_d = dibit_q;
    samp_d  = samp_q;
    pkt_d   = pkt_q;
    case (state_q)
      IDLE: begin
        if (w_s_hs) begin
          state_d = RUN;
          word_d  = s_axis_tdata;
          last_d  = s_axis_tlast;
          amp_d   = amp;
          dibit_d = '0;
          samp_d  = '0;
        end
      end
      RUN: begin
        if (w_m_hs) begin
          pkt_d = w_tlast ? '0 : pkt_q + 1'b1;
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            dibit_d = dibit_q + 1'b1;
            if (dibit_q == DIBIT_LAST) begin
              state_d = IDLE;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      amp_q   <= '0;
      last_q  <= 1'b0;
      dibit_q <= '0;
      samp_q  <= '0;
      pkt_q   <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      word_q  <= '0;
      amp_q   <= '0;
      last_q  <= 1'b0;
      dibit_q <= '0;
      samp_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      amp_q   <= amp_d;
      last_q  <= last_d;
      dibit_q <= dibit_d;
      samp_q  <= samp_d;
      pkt_q   <= pkt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qpsk_mod_tx.sv
`default_nettype none
// ============================================================================
// tb_qpsk_mod_tx - directed self-checking bench for the QPSK transmit modulator
// Rev 1.0
// ============================================================================
module tb_qpsk_mod_tx;

  logic        ce_clk = 1'b0;
  logic        ce_rst;
  logic        clear;
  logic [14:0] amp;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_valid;
  logic        m_ready;

  logic        s_ready, m_last, m_valid, busy;
  logic [31:0] m_data;
  logic        s_ready100, m_last100, m_valid100, busy100;
  logic [31:0] m_data100;

  int n_cmp = 0;
  int n_err = 0;
  int dual_bad = 0;

  logic [31:0] cap_data [0:767];
  logic        cap_last [0:767];
  logic        cap_last100 [0:767];
  logic [31:0] ref_data [0:255];
  logic        ref_last [0:255];

  always #5 ce_clk = ~ce_clk;

  qpsk_mod_tx #(.SPS(16), .PKT_LEN(256)) u_dut (
    .ce_clk        (ce_clk),
    .ce_rst        (ce_rst),
    .clear         (clear),
    .amp           (amp),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .busy          (busy)
  );

  qpsk_mod_tx #(.SPS(16), .PKT_LEN(100)) u_dut100 (
    .ce_clk        (ce_clk),
    .ce_rst        (ce_rst),
    .clear         (clear),
    .amp           (amp),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready100),
    .m_axis_tdata  (m_data100),
    .m_axis_tlast  (m_last100),
    .m_axis_tvalid (m_valid100),
    .m_axis_tready (m_ready),
    .busy          (busy100)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ce_rst  = 1'b1;
    clear   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge ce_clk);
    #1;
    chk("rst_sready", {31'b0, s_ready}, 32'd0);
    chk("rst_mvalid", {31'b0, m_valid}, 32'd0);
    chk("rst_mlast", {31'b0, m_last}, 32'd0);
    chk("rst_mdata", m_data, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mvalid100", {31'b0, m_valid100 | busy100}, 32'd0);
    ce_rst = 1'b0;
    @(posedge ce_clk);
    #1;
    chk("idle_sready", {31'b0, s_ready}, 32'd1);
    chk("idle_sready100", {31'b0, s_ready100}, 32'd1);
    chk("idle_mvalid", {31'b0, m_valid}, 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic l, input logic [14:0] a);
    int  cyc;
    bit  done;
    s_data  = w;
    s_last  = l;
    amp     = a;
    s_valid = 1'b1;
    done    = 1'b0;
    cyc     = 0;
    while (!done && cyc < 20) begin
      done = s_ready;
      @(posedge ce_clk);
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    amp     = 15'h1234;
    chk("accept", {31'b0, done}, 32'd1);
    chk("latency1_valid", {31'b0, m_valid}, 32'd1);
  endtask

  task automatic collect(input int base, input int n, input bit rnd);
    int          beats;
    int          cyc;
    int          bad_sr;
    logic        stalled;
    logic [31:0] sd;
    logic        sl;
    beats   = 0;
    cyc     = 0;
    bad_sr  = 0;
    stalled = 1'b0;
    sd      = '0;
    sl      = 1'b0;
    while (beats < n && cyc < n * 4 + 64) begin
      if (stalled) begin
        chk("stall_data", m_data, sd);
        chk("stall_last", {31'b0, m_last}, {31'b0, sl});
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && s_ready) bad_sr++;
      if (m_valid && m_ready) begin
        cap_data[base + beats]    = m_data;
        cap_last[base + beats]    = m_last;
        cap_last100[base + beats] = m_last100;
        if (m_data100 !== m_data) dual_bad++;
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = m_valid;
        sd      = m_data;
        sl      = m_last;
      end
      @(posedge ce_clk);
      #1;
      cyc++;
    end
    m_ready = 1'b0;
    chk("beat_count", 32'(beats), 32'(n));
    chk("sready_low_in_run", 32'(bad_sr), 32'd0);
  endtask

  task automatic reset_mid(input bit use_clear);
    int bad;
    int nl;
    do_reset();
    send_word(32'h1B000000, 1'b1, 15'h4000);
    collect(0, 40, 1'b0);
    if (use_clear) begin
      clear = 1'b1;
      @(posedge ce_clk);
      #1;
      clear = 1'b0;
    end else begin
      ce_rst = 1'b1;
      #1;
      chk("mid_rst_sready", {31'b0, s_ready}, 32'd0);
      @(posedge ce_clk);
      @(posedge ce_clk);
      #1;
      ce_rst = 1'b0;
    end
    chk("mid_mvalid", {31'b0, m_valid}, 32'd0);
    chk("mid_mlast", {31'b0, m_last}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    @(posedge ce_clk);
    #1;
    chk("mid_after_sready", {31'b0, s_ready}, 32'd1);
    chk("mid_after_mvalid", {31'b0, m_valid}, 32'd0);
    send_word(32'h40000000, 1'b0, 15'h4000);
    collect(0, 256, 1'b0);
    bad = 0;
    nl  = 0;
    for (int b = 0; b < 16; b++) if (cap_data[b] !== 32'h4000C000) bad++;
    for (int b = 0; b < 256; b++) if (cap_last[b] === 1'b1) nl++;
    chk("mid_next_first16", 32'(bad), 32'd0);
    chk("mid_next_tlast_cnt", 32'(nl), 32'd1);
    chk("mid_next_tlast255", {31'b0, cap_last[255]}, 32'd1);
    chk("mid_next_tlast100_99", {31'b0, cap_last100[99]}, 32'd1);
    chk("mid_next_tlast100_39", {31'b0, cap_last100[39]}, 32'd0);
  endtask

  initial begin
    int          bad;
    int          nl;
    int          pc;
    logic        e;
    logic [31:0] exp;

    ce_rst  = 1'b1;
    clear   = 1'b0;
    amp     = '0;
    s_data  = '0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;

    // Mapping and symbol order
    do_reset();
    send_word(32'h1B000000, 1'b1, 15'h4000);
    collect(0, 256, 1'b0);
    nl = 0;
    for (int b = 0; b < 256; b++) begin
      exp = (b < 16) ? 32'h40004000 : (b < 32) ? 32'h4000C000 :
            (b < 48) ? 32'hC0004000 : (b < 64) ? 32'hC000C000 : 32'h40004000;
      chk($sformatf("map_data[%0d]", b), cap_data[b], exp);
      if (cap_last[b] === 1'b1) nl++;
      ref_data[b] = cap_data[b];
      ref_last[b] = cap_last[b];
    end
    chk("map_tlast_cnt", 32'(nl), 32'd1);
    chk("map_tlast_255", {31'b0, cap_last[255]}, 32'd1);
    chk("map_idle_mvalid", {31'b0, m_valid}, 32'd0);
    chk("map_idle_sready", {31'b0, s_ready}, 32'd1);

    // Magnitude extremes
    do_reset();
    send_word(32'hFFFFFFFF, 1'b0, 15'h7FFF);
    collect(0, 256, 1'b0);
    bad = 0;
    for (int b = 0; b < 256; b++) if (cap_data[b] !== 32'h80018001) bad++;
    chk("mag_7fff_bad", 32'(bad), 32'd0);
    send_word(32'hFFFFFFFF, 1'b0, 15'h0000);
    collect(0, 256, 1'b0);
    bad = 0;
    for (int b = 0; b < 256; b++) if (cap_data[b] !== 32'h00000000) bad++;
    chk("mag_zero_bad", 32'(bad), 32'd0);

    // Random backpressure must reproduce the unstalled beat sequence
    do_reset();
    send_word(32'h1B000000, 1'b1, 15'h4000);
    collect(0, 256, 1'b1);
    bad = 0;
    for (int b = 0; b < 256; b++)
      if (cap_data[b] !== ref_data[b] || cap_last[b] !== ref_last[b]) bad++;
    chk("bp_seq_bad", 32'(bad), 32'd0);

    // Packetizing (PKT_LEN=100) and coincident tlast (PKT_LEN=256)
    do_reset();
    dual_bad = 0;
    send_word(32'h1B000000, 1'b1, 15'h4000);
    collect(0, 256, 1'b0);
    send_word(32'h12345678, 1'b0, 15'h2000);
    collect(256, 256, 1'b0);
    send_word(32'h9ABCDEF0, 1'b0, 15'h0123);
    collect(512, 256, 1'b0);
    chk("pkt_dual_data", 32'(dual_bad), 32'd0);
    bad = 0;
    pc  = 0;
    for (int b = 0; b < 768; b++) begin
      e = (pc == 99) || (b == 255);
      if (cap_last100[b] !== e) bad++;
      pc = e ? 0 : pc + 1;
    end
    chk("pkt100_tlast_bad", 32'(bad), 32'd0);
    chk("pkt100_tlast_99", {31'b0, cap_last100[99]}, 32'd1);
    chk("pkt100_tlast_199", {31'b0, cap_last100[199]}, 32'd1);
    chk("pkt100_tlast_255", {31'b0, cap_last100[255]}, 32'd1);
    chk("pkt100_tlast_299", {31'b0, cap_last100[299]}, 32'd0);
    chk("pkt100_tlast_355", {31'b0, cap_last100[355]}, 32'd1);
    bad = 0;
    pc  = 0;
    for (int b = 0; b < 768; b++) begin
      e = (pc == 255) || (b == 255);
      if (cap_last[b] !== e) bad++;
      pc = e ? 0 : pc + 1;
    end
    chk("pkt256_tlast_bad", 32'(bad), 32'd0);
    nl = 0;
    for (int b = 0; b < 256; b++) if (cap_last[b] === 1'b1) nl++;
    chk("coinc_tlast_cnt", 32'(nl), 32'd1);
    chk("coinc_tlast_511", {31'b0, cap_last[511]}, 32'd1);

    // Asynchronous reset, then synchronous clear, mid-word
    reset_mid(1'b0);
    reset_mid(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
